// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM state encoding, direction codes,
// and the per-step carry selection.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // The bit leaving the operand on one step depends only on the direction.
    function automatic logic step_carry(input logic dir,
                                        input logic bb_left,
                                        input logic bb_right);
        return (dir == DIR_RIGHT) ? bb_right : bb_left;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_shift_4_bit.sv
// Single-position 4-bit shifter (combinational). select=0 shifts left,
// select=1 shifts right; bb_left/bb_right expose the bits leaving each edge.
module shift_4_bit (
    output logic [3:0] S,
    output logic       bb_right,
    output logic       bb_left,
    input  logic [3:0] D,
    input  logic       shift_in_right,
    input  logic       shift_in_left,
    input  logic       select
);

    always_comb begin
        if (select) begin
            S = {shift_in_left, D[3:1]};
        end else begin
            S = {D[2:0], shift_in_right};
        end
        bb_left  = D[3];
        bb_right = D[0];
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer driving one shift_4_bit per clock.
// Define SHIFT_SEQ_ROTATE_EN to honour in_rot (rotate instead of shift).
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_arith,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_carry,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [3:0]       work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;
    logic             rot_q;

    logic [3:0]       sh_s;
    logic             sh_bb_left, sh_bb_right;
    logic             sh_in_right, sh_in_left;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_d;
`else
    logic unused_rot;
    assign unused_rot = in_rot;
    assign rot_q      = 1'b0;
`endif

    shift_4_bit u_shift (
        .S              (sh_s),
        .bb_right       (sh_bb_right),
        .bb_left        (sh_bb_left),
        .D              (work_q),
        .shift_in_right (sh_in_right),
        .shift_in_left  (sh_in_left),
        .select         (dir_q)
    );

    // Fill mux: rotate wins over arithmetic fill; unused shift-in stays 0.
    always_comb begin
        sh_in_right = 1'b0;
        sh_in_left  = 1'b0;
        if (dir_q == DIR_LEFT) begin
            sh_in_right = rot_q ? work_q[3] : 1'b0;
        end else begin
            sh_in_left = rot_q ? work_q[0] : (arith_q ? work_q[3] : 1'b0);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        dir_d   = dir_q;
        arith_d = arith_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    dir_d   = in_dir;
                    arith_d = in_arith;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d   = in_rot;
`endif
                    cnt_d   = in_amt;
                    carry_d = 1'b0;
                    state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d  = sh_s;
                cnt_d   = cnt_q - AMT_W'(1);
                carry_d = step_carry(dir_q, sh_bb_left, sh_bb_right);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign out_data  = work_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, reset and
// backpressure sequences, exhaustive and random ops against a reference model.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       in_dir = 1'b0;
    logic [2:0] in_amt = '0;
    logic       in_arith = 1'b0;
    logic       in_rot = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_carry;
    logic       busy;

    int num_tests = 0;
    int num_wrong = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.AMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .in_arith  (in_arith),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] d;
        logic       dir;
        logic [2:0] amt;
        logic       arith;
        logic       rot;
        int         hold;
        logic [3:0] exp_d;
        logic       exp_c;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_tests++;
        if (act !== exp) begin
            num_wrong++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-operation result from plain arithmetic on the operand.
    function automatic logic [4:0] ref_shift(input logic [3:0] d, input logic dir,
                                             input int amt, input logic arith,
                                             input logic rot);
        int v, c, s, k;
        if (amt == 0) return {1'b0, d};
        v = 0;
        c = 0;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rot) begin
            k = amt % 4;
            if (dir == 1'b0) v = ((int'(d) << k) | (int'(d) >> (4 - k))) & 15;
            else             v = ((int'(d) >> k) | (int'(d) << (4 - k))) & 15;
            c = (dir == 1'b0) ? (v & 1) : ((v >> 3) & 1);
            return {c[0], v[3:0]};
        end
`else
        k = int'(rot);
`endif
        if (dir == 1'b0) begin
            v = int'(d) << amt;
            c = (v >> 4) & 1;
        end else if (arith) begin
            s = d[3] ? int'(d) - 16 : int'(d);
            v = s >>> amt;
            c = (s >>> (amt - 1)) & 1;
        end else begin
            v = int'(d) >> amt;
            c = (int'(d) >> (amt - 1)) & 1;
        end
        return {c[0], v[3:0]};
    endfunction

    task automatic do_op(input logic [3:0] d, input logic dir, input logic [2:0] amt,
                         input logic arith, input logic rot, input int hold,
                         input logic [3:0] exp_d, input logic exp_c, input string name);
        int cycles;
        logic [3:0] held_d;
        logic held_c;
        @(negedge clk);
        cycles = 0;
        while (!in_ready && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        chk({name, ".ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_amt   = amt;
        in_arith = arith;
        in_rot   = rot;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_dir   = 1'($urandom);
        in_arith = 1'($urandom);
        in_rot   = 1'($urandom);
        in_amt   = 3'($urandom);
        cycles = 1;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({name, ".latency"}, cycles, int'(amt) + 1);
        chk({name, ".data"}, out_data, exp_d);
        chk({name, ".carry"}, out_carry, exp_c);
        chk({name, ".busy"}, busy, 1);
        held_d = out_data;
        held_c = out_carry;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, ".hold_valid"}, out_valid, 1);
            chk({name, ".hold_data"}, out_data, held_d);
            chk({name, ".hold_carry"}, out_carry, held_c);
            chk({name, ".hold_in_ready"}, in_ready, 0);
            chk({name, ".hold_busy"}, busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, ".idle_ready"}, in_ready, 1);
        chk({name, ".idle_valid"}, out_valid, 0);
        chk({name, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] r;
        logic [3:0] d;
        logic [2:0] a;
        logic dir, ar, ro;

        vecs[0] = '{4'b1011, 1'b0, 3'd1, 1'b0, 1'b0, 0, 4'b0110, 1'b1};
        vecs[1] = '{4'b1011, 1'b1, 3'd2, 1'b0, 1'b0, 0, 4'b0010, 1'b1};
        vecs[2] = '{4'b1000, 1'b1, 3'd3, 1'b1, 1'b0, 0, 4'b1111, 1'b0};
        vecs[3] = '{4'b1000, 1'b1, 3'd7, 1'b0, 1'b0, 0, 4'b0000, 1'b0};
        vecs[4] = '{4'b1010, 1'b0, 3'd0, 1'b0, 1'b0, 0, 4'b1010, 1'b0};
        vecs[5] = '{4'b0110, 1'b0, 3'd2, 1'b0, 1'b0, 3, 4'b1000, 1'b1};
`ifdef SHIFT_SEQ_ROTATE_EN
        vecs[6] = '{4'b1001, 1'b0, 3'd1, 1'b0, 1'b1, 0, 4'b0011, 1'b1};
        vecs[7] = '{4'b0001, 1'b1, 3'd1, 1'b1, 1'b1, 0, 4'b1000, 1'b1};
`else
        vecs[6] = '{4'b1001, 1'b0, 3'd1, 1'b0, 1'b1, 0, 4'b0010, 1'b1};
        vecs[7] = '{4'b0001, 1'b1, 3'd1, 1'b0, 1'b1, 0, 4'b0000, 1'b1};
`endif

        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_carry", out_carry, 0);
        chk("rst.busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].d, vecs[i].dir, vecs[i].amt, vecs[i].arith, vecs[i].rot,
                  vecs[i].hold, vecs[i].exp_d, vecs[i].exp_c, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a long shift discards everything.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1011;
        in_dir   = 1'b0;
        in_amt   = 3'd5;
        in_arith = 1'b0;
        in_rot   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrst.busy_before", busy, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.out_data", out_data, 0);
        chk("midrst.out_carry", out_carry, 0);
        chk("midrst.busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("midrst.no_result", out_valid, 0);

        for (int di = 0; di < 16; di++) begin
            for (int ai = 0; ai < 8; ai++) begin
                for (int dr = 0; dr < 2; dr++) begin
                    d  = 4'(di);
                    a  = 3'(ai);
                    dir = 1'(dr);
                    ar = 1'($urandom);
                    ro = 1'($urandom);
                    r  = ref_shift(d, dir, ai, ar, ro);
                    do_op(d, dir, a, ar, ro, 0, r[3:0], r[4],
                          $sformatf("ex_d%0h_a%0d_r%0d", di, ai, dr));
                end
            end
        end

        for (int n = 0; n < 150; n++) begin
            d   = 4'($urandom);
            a   = 3'($urandom);
            dir = 1'($urandom);
            ar  = 1'($urandom);
            ro  = 1'($urandom);
            r   = ref_shift(d, dir, int'(a), ar, ro);
            do_op(d, dir, a, ar, ro, int'($urandom_range(0, 3)), r[3:0], r[4],
                  $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", num_tests, num_wrong);
        $finish;
    end

endmodule
